// File: rtl/tinyalu_pkg.sv
// rtl/tinyalu_pkg.sv - shared op encodings, state and owner types for the tinyalu arbiter
// Purpose: common types and helpers imported by the arbiter top and its grant sub-module.
// Ports: none (package).
package tinyalu_pkg;

    localparam logic [2:0] NO_OP  = 3'b000;
    localparam logic [2:0] ADD    = 3'b001;
    localparam logic [2:0] AND    = 3'b010;
    localparam logic [2:0] XOR    = 3'b011;
    localparam logic [2:0] MUL    = 3'b100;
    localparam logic [2:0] RST_OP = 3'b111;

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_ISSUE,
        ST_RELEASE,
        ST_RESP
    } arb_state_e;

    typedef enum logic {
        OWN_A,
        OWN_B
    } owner_e;

    // Ops that are actually forwarded to the ALU.
    function automatic logic op_uses_alu(input logic [2:0] op);
        return (op == ADD) || (op == AND) || (op == XOR) || (op == MUL);
    endfunction

    // Ops answered locally with an error; RST_OP is named explicitly because
    // letting a requester reset the shared ALU would corrupt the other side.
    function automatic logic op_is_illegal(input logic [2:0] op);
        return (op == RST_OP) || (op > MUL);
    endfunction

endpackage

// File: rtl/tinyalu_arbiter_if.sv
// rtl/tinyalu_arbiter_if.sv - command/response and ALU pin bundle for the tinyalu arbiter
// Purpose: groups both requester ports and the ALU pins.
// Modports: slave  - the arbiter (consumes commands, produces responses, drives ALU pins)
//           master - the environment (requesters plus the ALU itself)
interface tinyalu_arbiter_if;

    logic        req_valid_a;
    logic        req_ready_a;
    logic [7:0]  req_A_a;
    logic [7:0]  req_B_a;
    logic [2:0]  req_op_a;
    logic        req_valid_b;
    logic        req_ready_b;
    logic [7:0]  req_A_b;
    logic [7:0]  req_B_b;
    logic [2:0]  req_op_b;

    logic        rsp_valid_a;
    logic        rsp_ready_a;
    logic [15:0] rsp_result_a;
    logic        rsp_err_a;
    logic        rsp_valid_b;
    logic        rsp_ready_b;
    logic [15:0] rsp_result_b;
    logic        rsp_err_b;

    logic [7:0]  alu_A;
    logic [7:0]  alu_B;
    logic [2:0]  alu_op;
    logic        alu_start;
    logic        alu_done;
    logic [15:0] alu_result;

    modport slave (
        input  req_valid_a, req_A_a, req_B_a, req_op_a,
        input  req_valid_b, req_A_b, req_B_b, req_op_b,
        output req_ready_a, req_ready_b,
        output rsp_valid_a, rsp_result_a, rsp_err_a,
        output rsp_valid_b, rsp_result_b, rsp_err_b,
        input  rsp_ready_a, rsp_ready_b,
        output alu_A, alu_B, alu_op, alu_start,
        input  alu_done, alu_result
    );

    modport master (
        output req_valid_a, req_A_a, req_B_a, req_op_a,
        output req_valid_b, req_A_b, req_B_b, req_op_b,
        input  req_ready_a, req_ready_b,
        input  rsp_valid_a, rsp_result_a, rsp_err_a,
        input  rsp_valid_b, rsp_result_b, rsp_err_b,
        output rsp_ready_a, rsp_ready_b,
        input  alu_A, alu_B, alu_op, alu_start,
        output alu_done, alu_result
    );

endinterface

// File: rtl/tinyalu_rr_arb2.sv
// rtl/tinyalu_rr_arb2.sv - two-way round-robin grant
// Purpose: combinational grant from the two request valids and the last-served owner.
// Ports: valid_a/valid_b in  - request valids
//        last            in  - owner served most recently
//        grant_a/grant_b out - one-hot (or zero) grant
module tinyalu_rr_arb2
    import tinyalu_pkg::*;
(
    input  logic   valid_a,
    input  logic   valid_b,
    input  owner_e last,
    output logic   grant_a,
    output logic   grant_b
);

    // On a tie the requester not served last wins, so the grants are mutually exclusive.
    always_comb begin
        grant_a = valid_a && (!valid_b || (last == OWN_B));
        grant_b = valid_b && (!valid_a || (last == OWN_A));
    end

endmodule

// File: rtl/tinyalu_arbiter.sv
// rtl/tinyalu_arbiter.sv - round-robin sequencer sharing one tinyalu between two requesters
// Purpose: arbitrates commands from A and B, drives the ALU start/operand pins, filters
//          illegal ops, bounds each op with a timeout and returns the result to its owner.
// Ports: clk, reset_n  - clock, synchronous active-low reset
//        bus (slave)   - requester command/response ports and ALU pins
//        busy          - high whenever the sequencer is not IDLE
//        timeout_cnt   - saturating count of timed-out ops
module tinyalu_arbiter
    import tinyalu_pkg::*;
#(
    parameter int unsigned TIMEOUT = 15
) (
    input  logic             clk,
    input  logic             reset_n,
    tinyalu_arbiter_if.slave bus,
    output logic             busy,
    output logic [7:0]       timeout_cnt
);

    localparam logic [7:0] CNT_LAST = 8'(TIMEOUT - 1);

    arb_state_e  state_q, state_d;
    owner_e      last_q, last_d;
    owner_e      owner_q, owner_d;
    logic [7:0]  cnt_q, cnt_d;
    logic [7:0]  alu_a_q, alu_a_d;
    logic [7:0]  alu_b_q, alu_b_d;
    logic [2:0]  alu_op_q, alu_op_d;
    logic        alu_start_q, alu_start_d;
    logic [15:0] result_q, result_d;
    logic        err_q, err_d;
    logic        rsp_valid_q, rsp_valid_d;
    logic [7:0]  timeout_cnt_q, timeout_cnt_d;

    logic        grant_a;
    logic        grant_b;
    logic        accept;
    owner_e      sel;
    logic [7:0]  sel_a;
    logic [7:0]  sel_b;
    logic [2:0]  sel_op;
    logic        rsp_ready_own;

    tinyalu_rr_arb2 u_arb (
        .valid_a (bus.req_valid_a),
        .valid_b (bus.req_valid_b),
        .last    (last_q),
        .grant_a (grant_a),
        .grant_b (grant_b)
    );

    assign bus.req_ready_a = (state_q == ST_IDLE) && grant_a;
    assign bus.req_ready_b = (state_q == ST_IDLE) && grant_b;
    assign accept = (bus.req_ready_a && bus.req_valid_a) || (bus.req_ready_b && bus.req_valid_b);

    always_comb begin
        sel    = grant_b ? OWN_B : OWN_A;
        sel_a  = grant_b ? bus.req_A_b  : bus.req_A_a;
        sel_b  = grant_b ? bus.req_B_b  : bus.req_B_a;
        sel_op = grant_b ? bus.req_op_b : bus.req_op_a;
        rsp_ready_own = (owner_q == OWN_B) ? bus.rsp_ready_b : bus.rsp_ready_a;
    end

    always_comb begin
        state_d       = state_q;
        last_d        = last_q;
        owner_d       = owner_q;
        cnt_d         = cnt_q;
        alu_a_d       = alu_a_q;
        alu_b_d       = alu_b_q;
        alu_op_d      = alu_op_q;
        alu_start_d   = alu_start_q;
        result_d      = result_q;
        err_d         = err_q;
        rsp_valid_d   = rsp_valid_q;
        timeout_cnt_d = timeout_cnt_q;

        case (state_q)
            ST_IDLE: begin
                if (accept) begin
                    owner_d = sel;
                    last_d  = sel;
                    if (op_uses_alu(sel_op)) begin
                        state_d     = ST_ISSUE;
                        cnt_d       = 8'd0;
                        alu_start_d = 1'b1;
                        alu_a_d     = sel_a;
                        alu_b_d     = sel_b;
                        alu_op_d    = sel_op;
                    end else begin
                        // NO_OP and illegal ops are answered without touching the ALU.
                        state_d     = ST_RESP;
                        rsp_valid_d = 1'b1;
                        result_d    = 16'h0000;
                        err_d       = op_is_illegal(sel_op);
                    end
                end
            end

            ST_ISSUE: begin
                // done is checked first so a completion in the last allowed cycle still succeeds
                if (bus.alu_done) begin
                    state_d     = ST_RELEASE;
                    result_d    = bus.alu_result;
                    err_d       = 1'b0;
                    alu_start_d = 1'b0;
                    alu_a_d     = 8'h00;
                    alu_b_d     = 8'h00;
                    alu_op_d    = 3'b000;
                end else if (cnt_q == CNT_LAST) begin
                    state_d     = ST_RELEASE;
                    result_d    = 16'h0000;
                    err_d       = 1'b1;
                    alu_start_d = 1'b0;
                    alu_a_d     = 8'h00;
                    alu_b_d     = 8'h00;
                    alu_op_d    = 3'b000;
                    if (timeout_cnt_q != 8'hFF) begin
                        timeout_cnt_d = timeout_cnt_q + 8'd1;
                    end
                end else begin
                    cnt_d = cnt_q + 8'd1;
                end
            end

            // One cycle with start low so the ALU always sees a gap between ops.
            ST_RELEASE: begin
                state_d     = ST_RESP;
                rsp_valid_d = 1'b1;
            end

            ST_RESP: begin
                if (rsp_ready_own) begin
                    state_d     = ST_IDLE;
                    rsp_valid_d = 1'b0;
                end
            end

            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (!reset_n) begin
            state_q       <= ST_IDLE;
            last_q        <= OWN_B;
            owner_q       <= OWN_A;
            cnt_q         <= 8'd0;
            alu_a_q       <= 8'h00;
            alu_b_q       <= 8'h00;
            alu_op_q      <= 3'b000;
            alu_start_q   <= 1'b0;
            result_q      <= 16'h0000;
            err_q         <= 1'b0;
            rsp_valid_q   <= 1'b0;
            timeout_cnt_q <= 8'd0;
        end else begin
            state_q       <= state_d;
            last_q        <= last_d;
            owner_q       <= owner_d;
            cnt_q         <= cnt_d;
            alu_a_q       <= alu_a_d;
            alu_b_q       <= alu_b_d;
            alu_op_q      <= alu_op_d;
            alu_start_q   <= alu_start_d;
            result_q      <= result_d;
            err_q         <= err_d;
            rsp_valid_q   <= rsp_valid_d;
            timeout_cnt_q <= timeout_cnt_d;
        end
    end

    assign bus.alu_A     = alu_a_q;
    assign bus.alu_B     = alu_b_q;
    assign bus.alu_op    = alu_op_q;
    assign bus.alu_start = alu_start_q;

    // Only the owner sees the response; the other side stays all-zero.
    assign bus.rsp_valid_a  = rsp_valid_q && (owner_q == OWN_A);
    assign bus.rsp_valid_b  = rsp_valid_q && (owner_q == OWN_B);
    assign bus.rsp_result_a = bus.rsp_valid_a ? result_q : 16'h0000;
    assign bus.rsp_result_b = bus.rsp_valid_b ? result_q : 16'h0000;
    assign bus.rsp_err_a    = bus.rsp_valid_a && err_q;
    assign bus.rsp_err_b    = bus.rsp_valid_b && err_q;

    assign busy        = (state_q != ST_IDLE);
    assign timeout_cnt = timeout_cnt_q;

endmodule

// File: doc/tinyalu_arbiter.md
# tinyalu_arbiter

Round-robin arbiter and sequencer that shares one `tinyalu` datapath between two requesters (A and B). Each requester uses a valid/ready command port and a valid/ready response port. The block drives the ALU operand, op and start pins, holds start until done, and returns the result to the owning requester. It filters illegal ops, including the ALU's reset op, and bounds every operation with a timeout.

## Interface
- `TIMEOUT`, default 15: maximum cycles spent in ISSUE waiting for `alu_done`; legal range 2..255.
- `clk` in 1: single clock; all logic is rising-edge.
- `reset_n` in 1: synchronous, active-low reset.
- `req_valid_a`/`req_valid_b` in 1: command valid.
- `req_ready_a`/`req_ready_b` out 1: command accepted when valid && ready.
- `req_A_a`/`req_A_b` in 8, `req_B_a`/`req_B_b` in 8, `req_op_a`/`req_op_b` in 3: operands and op.
- `rsp_valid_a`/`rsp_valid_b` out 1: response valid.
- `rsp_ready_a`/`rsp_ready_b` in 1: response consumed when valid && ready.
- `rsp_result_a`/`rsp_result_b` out 16: result.
- `rsp_err_a`/`rsp_err_b` out 1: 1 for an illegal op or a timeout.
- `alu_A` out 8, `alu_B` out 8, `alu_op` out 3, `alu_start` out 1: to the ALU.
- `alu_done` in 1, `alu_result` in 16: from the ALU.
- `busy` out 1: state != IDLE.
- `timeout_cnt` out 8: saturating count of timeouts.

## Operation
- States: IDLE, ISSUE, RELEASE, RESP.
- **IDLE, grant:**
  - If only one requester is valid, grant it.
  - If both are valid, grant the one not served last.
  - The `last` pointer resets to B, so A wins the first tie.
  - `req_ready_x` = (state == IDLE) && grant == x. It is combinational and never high for both requesters.
- **IDLE, accept:**
  - On handshake, latch A, B, op and the owner, and set `last` = owner.
  - Ops 1..4 (ADD, AND, XOR, MUL) → ISSUE.
  - Op 0 (NO_OP) → RESP with result 0, err 0. The ALU is not touched.
  - Ops 5..7 (7 is RST_OP) → RESP with result 0, err 1. The ALU is not touched.
- **ISSUE:**
  - `alu_start` = 1; `alu_A`/`alu_B`/`alu_op` = latched values, held stable.
  - A cycle counter clears on entry.
  - `alu_done` high: capture `alu_result`, err 0 → RELEASE.
  - If the counter reaches TIMEOUT-1 with `alu_done` low: result 0, err 1, `timeout_cnt` += 1 (saturates at 255) → RELEASE.
  - `alu_done` in the final allowed cycle wins over timeout.
- **RELEASE:** `alu_start` = 0 for exactly one cycle, guaranteeing a start low gap between ops → RESP.
- **RESP:**
  - `rsp_valid_owner` = 1; result and err are held stable until `rsp_ready_owner`, then → IDLE.
  - The other requester's rsp_valid stays 0.
- `alu_done` outside ISSUE is ignored.
- `alu_A`/`alu_B`/`alu_op` are 0 whenever the state is not ISSUE.

## Timing
- **Reset values:** all outputs 0, state IDLE, `timeout_cnt` 0, `last` = B.
- **Reset mid-operation:** `alu_start` drops at the reset edge and any pending response is discarded.
- **Legal op:** accepted at edge 0; `alu_start` is high from cycle 1.
  - If done is sampled at ISSUE cycle k, RELEASE is cycle k+1 and `rsp_valid` rises at cycle k+2.
  - Best-case turnaround (done in the first ISSUE cycle): rsp_valid at cycle 3.
- **Filtered op:** `rsp_valid` rises one cycle after accept.
- **Throughput:** one outstanding op. The next accept is possible in the cycle after the rsp handshake (IDLE).
- **Timeout:** `alu_start` is high for exactly TIMEOUT cycles.

## Structure
- Shared package `tinyalu_pkg`:
  - op encodings: NO_OP = 3'b000, ADD = 001, AND = 010, XOR = 011, MUL = 100, RST_OP = 111;
  - arbiter state enum;
  - owner enum (OWN_A, OWN_B).
- Sub-module `tinyalu_rr_arb2`: combinational grant from the two valids and `last`.
- FSM, latches and counters live in `tinyalu_arbiter`.

## Test plan
- **Single add:** A sends A=8'h05, B=8'h03, op=001; the ALU model gives done in ISSUE cycle 1 with 16'h0008. Required: `rsp_result_a` = 16'h0008, err 0, `alu_start` high 1 cycle then low 1 cycle.
- **Multiply:** B sends A=8'hFF, B=8'hFF, op=100; done after 3 cycles. Required: `alu_start` high 3 cycles, operands stable, `rsp_result_b` = 16'hFE01.
- **Fairness:** both valid continuously after reset, 4 ops each. Required: grant order A, B, A, B, …; `req_ready` is never high for both.
- **Illegal ops:** B sends op=111, then op=000. Required: `alu_start` never rises; responses are (0, err 1) then (0, err 0), one cycle after accept.
- **Timeout:** TIMEOUT=15, ALU never asserts done. Required: `alu_start` high exactly 15 cycles, `rsp_err_a` = 1, result 0, `timeout_cnt` = 1.
- **Backpressure and reset:**
  - Hold `rsp_ready_a` low 5 cycles. Required: result stable and both `req_ready` = 0 throughout.
  - Assert `reset_n` low mid-ISSUE. Required: all outputs 0 next cycle; no response is delivered.
